// File: rtl/pwm_multi_driver.sv
`default_nettype none
// ============================================================================
// Module      : pwm_multi_driver
// Description : Multi-channel PWM generator. One shared prescaler and period
//               counter (edge- or center-aligned) feed a per-channel duty
//               compare. Configuration is double-buffered (staging -> active)
//               and only swapped at a period boundary, so no runt pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_multi_driver #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      enable_in,
  input  logic                      update_in,
  input  logic [WIDTH-1:0]          period_in,
  input  logic [PRESCALE_W-1:0]     prescale_in,
  input  logic                      center_mode_in,
  input  logic [CHANNELS*WIDTH-1:0] duty_in,
  input  logic [CHANNELS-1:0]       polarity_in,
  output logic                      update_ack_out,
  output logic                      period_start_out,
  output logic [CHANNELS-1:0]       pwm_out
);

  // Prescaler and period counter state
  logic [PRESCALE_W-1:0]     presc_q, presc_d;
  logic [WIDTH-1:0]          cnt_q, cnt_d;
  logic                      down_q, down_d;

  // Active (in-use) configuration
  logic [WIDTH-1:0]          period_act_q;
  logic [PRESCALE_W-1:0]     prescale_act_q;
  logic                      center_act_q;
  logic [CHANNELS*WIDTH-1:0] duty_act_q;
  logic [CHANNELS-1:0]       pol_act_q;

  // Staging configuration, written by update_in
  logic [WIDTH-1:0]          period_stg_q;
  logic [PRESCALE_W-1:0]     prescale_stg_q;
  logic                      center_stg_q;
  logic [CHANNELS*WIDTH-1:0] duty_stg_q;
  logic [CHANNELS-1:0]       pol_stg_q;
  logic                      pending_q, pending_d;

  // Output pipeline: bnd_q/ld_q sit at cnt timing, outputs one clock later
  logic                      bnd_q, ld_q;
  logic [CHANNELS-1:0]       pwm_q, pwm_d;
  logic                      pstart_q, ack_q;

  logic                      tick;
  logic                      boundary;
  logic                      load;
  logic [CHANNELS-1:0]       cmp_active;

  // Next-state for prescaler and period counter, boundary and load decisions
  always_comb begin
    presc_d  = presc_q;
    cnt_d    = cnt_q;
    down_d   = down_q;
    tick     = enable_in && (presc_q >= prescale_act_q);
    if (!enable_in) begin
      // Idle: hold both counters at the start of a period
      presc_d = '0;
      cnt_d   = '0;
      down_d  = 1'b0;
    end else begin
      presc_d = tick ? '0 : presc_q + PRESCALE_W'(1);
      if (tick) begin
        if (!center_act_q) begin
          cnt_d  = (cnt_q >= period_act_q) ? '0 : cnt_q + WIDTH'(1);
          down_d = 1'b0;
        end else if (down_q || (cnt_q >= period_act_q)) begin
          // Descending leg (or turning at the top). Reaching 0 ends the
          // period; period 0 keeps cnt pinned at 0.
          if (cnt_q <= WIDTH'(1)) begin
            cnt_d  = '0;
            down_d = 1'b0;
          end else begin
            cnt_d  = cnt_q - WIDTH'(1);
            down_d = 1'b1;
          end
        end else begin
          cnt_d  = cnt_q + WIDTH'(1);
          down_d = 1'b0;
        end
      end
    end
    boundary = tick && (cnt_d == '0);
    // Disabled: any pending config may be applied straight away
    load     = pending_q && (boundary || !enable_in);
    // A capture on a load cycle re-arms pending for the next boundary
    if (update_in)
      pending_d = 1'b1;
    else if (load)
      pending_d = 1'b0;
    else
      pending_d = pending_q;
  end

  // Per-channel duty compare against the current count
  for (genvar n = 0; n < CHANNELS; n++) begin : g_compare
    assign cmp_active[n] = (cnt_q < duty_act_q[n*WIDTH +: WIDTH]);
  end

  // Registered output value: idle level equals the polarity setting
  always_comb begin
    pwm_d = pol_act_q;
    if (enable_in)
      pwm_d = cmp_active ^ pol_act_q;
  end

  // Counter registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      presc_q <= '0;
      cnt_q   <= '0;
      down_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      down_q  <= down_d;
    end
  end

  // Staging capture and pending flag
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      period_stg_q   <= '1;
      prescale_stg_q <= '0;
      center_stg_q   <= 1'b0;
      duty_stg_q     <= '0;
      pol_stg_q      <= '0;
      pending_q      <= 1'b0;
    end else begin
      if (update_in) begin
        period_stg_q   <= period_in;
        prescale_stg_q <= prescale_in;
        center_stg_q   <= center_mode_in;
        duty_stg_q     <= duty_in;
        pol_stg_q      <= polarity_in;
      end
      pending_q <= pending_d;
    end
  end

  // Active configuration, swapped only on a load
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      period_act_q   <= '1;
      prescale_act_q <= '0;
      center_act_q   <= 1'b0;
      duty_act_q     <= '0;
      pol_act_q      <= '0;
    end else if (load) begin
      period_act_q   <= period_stg_q;
      prescale_act_q <= prescale_stg_q;
      center_act_q   <= center_stg_q;
      duty_act_q     <= duty_stg_q;
      pol_act_q      <= pol_stg_q;
    end
  end

  // Output pipeline; an idle counter sitting at 0 counts as a period start
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bnd_q    <= 1'b1;
      ld_q     <= 1'b0;
      pwm_q    <= '0;
      pstart_q <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      bnd_q    <= enable_in ? boundary : 1'b1;
      ld_q     <= load;
      pwm_q    <= pwm_d;
      pstart_q <= enable_in && bnd_q;
      ack_q    <= ld_q;
    end
  end

  assign pwm_out          = pwm_q;
  assign period_start_out = pstart_q;
  assign update_ack_out   = ack_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_multi_driver
// Description : Directed self-checking bench for pwm_multi_driver. Samples
//               all outputs on the falling clock edge; sample index i counts
//               clocks from a period_start pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_multi_driver;
  localparam int CH = 4;
  localparam int W  = 8;
  localparam int PW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enable;
  logic            update;
  logic [W-1:0]    period;
  logic [PW-1:0]   prescale;
  logic            center;
  logic [CH*W-1:0] duty;
  logic [CH-1:0]   pol;
  logic            ack;
  logic            pstart;
  logic [CH-1:0]   pwm;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pwm_multi_driver #(
    .CHANNELS  (CH),
    .WIDTH     (W),
    .PRESCALE_W(PW)
  ) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .enable_in       (enable),
    .update_in       (update),
    .period_in       (period),
    .prescale_in     (prescale),
    .center_mode_in  (center),
    .duty_in         (duty),
    .polarity_in     (pol),
    .update_ack_out  (ack),
    .period_start_out(pstart),
    .pwm_out         (pwm)
  );

  // One-cycle update pulse with the given config; returns on a falling edge
  task automatic configure(input logic [W-1:0] p, input logic [PW-1:0] ps,
                           input logic c, input logic [CH*W-1:0] d,
                           input logic [CH-1:0] po);
    @(negedge clk);
    period = p; prescale = ps; center = c; duty = d; pol = po; update = 1'b1;
    @(negedge clk);
    update = 1'b0;
  endtask

  // Disable, load a config while idle, let it settle
  task automatic load_idle(input logic [W-1:0] p, input logic [PW-1:0] ps,
                           input logic c, input logic [CH*W-1:0] d,
                           input logic [CH-1:0] po);
    enable = 1'b0;
    configure(p, ps, c, d, po);
    repeat (4) @(negedge clk);
  endtask

  // Enable and wait (bounded) for the first period_start sample
  task automatic start_run(output bit ok);
    enable = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (pstart === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1; enable = 1'b0; update = 1'b0;
    period = '0; prescale = '0; center = 1'b0; duty = '0; pol = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (pwm !== 4'b0000) begin fails++; $display("FAIL reset_pwm got=%b exp=0000", pwm); end
    tests++;
    if (pstart !== 1'b0) begin fails++; $display("FAIL reset_pstart got=%b exp=0", pstart); end
    tests++;
    if (ack !== 1'b0) begin fails++; $display("FAIL reset_ack got=%b exp=0", ack); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (pwm !== 4'b0000) begin fails++; $display("FAIL idle_after_reset got=%b exp=0000", pwm); end
  endtask

  // Edge mode, period 9, duties 0/3/10/255
  task automatic test_edge;
    bit ok;
    bit seen;
    logic [CH-1:0] exp;
    enable = 1'b0;
    configure(8'd9, 8'd0, 1'b0, {8'd255, 8'd10, 8'd3, 8'd0}, 4'b0000);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (ack === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    tests++;
    if (seen !== 1'b1) begin fails++; $display("FAIL idle_load_ack got=%b exp=1", seen); end
    start_run(ok);
    tests++;
    if (ok !== 1'b1) begin fails++; $display("FAIL edge_start got=timeout exp=pstart"); end
    for (int i = 0; i < 30; i++) begin
      exp = {1'b1, 1'b1, ((i % 10) < 3), 1'b0};
      tests++;
      if (pwm !== exp) begin fails++; $display("FAIL edge_pwm i=%0d got=%b exp=%b", i, pwm, exp); end
      tests++;
      if (pstart !== (i % 10 == 0)) begin fails++; $display("FAIL edge_pstart i=%0d got=%b exp=%b", i, pstart, (i % 10 == 0)); end
      @(negedge clk);
    end
  endtask

  // Prescale 3, period 4, duty 2: 8 high, 12 low
  task automatic test_prescale;
    bit ok;
    logic [CH-1:0] exp;
    load_idle(8'd4, 8'd3, 1'b0, {24'd0, 8'd2}, 4'b0000);
    start_run(ok);
    tests++;
    if (ok !== 1'b1) begin fails++; $display("FAIL presc_start got=timeout exp=pstart"); end
    for (int i = 0; i < 40; i++) begin
      exp = {3'b000, ((i % 20) < 8)};
      tests++;
      if (pwm !== exp) begin fails++; $display("FAIL presc_pwm i=%0d got=%b exp=%b", i, pwm, exp); end
      tests++;
      if (pstart !== (i % 20 == 0)) begin fails++; $display("FAIL presc_pstart i=%0d got=%b exp=%b", i, pstart, (i % 20 == 0)); end
      @(negedge clk);
    end
  endtask

  // Center mode, period 4 -> cnt 0,1,2,3,4,3,2,1; duty 2 high on cnt 0,1,(1)
  task automatic test_center;
    bit ok;
    logic [CH-1:0] exp;
    load_idle(8'd4, 8'd0, 1'b1, {24'd0, 8'd2}, 4'b0000);
    start_run(ok);
    tests++;
    if (ok !== 1'b1) begin fails++; $display("FAIL center_start got=timeout exp=pstart"); end
    for (int i = 0; i < 24; i++) begin
      exp = {3'b000, ((i % 8) < 2) || ((i % 8) == 7)};
      tests++;
      if (pwm !== exp) begin fails++; $display("FAIL center_pwm i=%0d got=%b exp=%b", i, pwm, exp); end
      tests++;
      if (pstart !== (i % 8 == 0)) begin fails++; $display("FAIL center_pstart i=%0d got=%b exp=%b", i, pstart, (i % 8 == 0)); end
      @(negedge clk);
    end
  endtask

  // Duty 3 -> 7 requested at cnt=5; applies at next boundary with ack
  task automatic test_update_mid_period;
    bit ok;
    logic [CH-1:0] exp;
    load_idle(8'd9, 8'd0, 1'b0, {24'd0, 8'd3}, 4'b0000);
    start_run(ok);
    tests++;
    if (ok !== 1'b1) begin fails++; $display("FAIL upd_start got=timeout exp=pstart"); end
    for (int i = 0; i < 30; i++) begin
      if (i < 10) exp = {3'b000, (i < 3)};
      else        exp = {3'b000, (((i - 10) % 10) < 7)};
      tests++;
      if (pwm !== exp) begin fails++; $display("FAIL upd_pwm i=%0d got=%b exp=%b", i, pwm, exp); end
      tests++;
      if (ack !== (i == 10)) begin fails++; $display("FAIL upd_ack i=%0d got=%b exp=%b", i, ack, (i == 10)); end
      tests++;
      if (pstart !== (i % 10 == 0)) begin fails++; $display("FAIL upd_pstart i=%0d got=%b exp=%b", i, pstart, (i % 10 == 0)); end
      if (i == 4) begin
        duty = {24'd0, 8'd7}; update = 1'b1;
      end else begin
        update = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  // Back-to-back updates (last wins), then an update on a boundary cycle
  task automatic test_back_to_back;
    bit ok;
    int d;
    logic [CH-1:0] exp;
    load_idle(8'd9, 8'd0, 1'b0, {24'd0, 8'd3}, 4'b0000);
    start_run(ok);
    tests++;
    if (ok !== 1'b1) begin fails++; $display("FAIL b2b_start got=timeout exp=pstart"); end
    for (int i = 0; i < 40; i++) begin
      d = (i < 10) ? 3 : (i < 30) ? 8 : 2;
      exp = {3'b000, ((i % 10) < d)};
      tests++;
      if (pwm !== exp) begin fails++; $display("FAIL b2b_pwm i=%0d got=%b exp=%b", i, pwm, exp); end
      tests++;
      if (ack !== (i == 10 || i == 30)) begin fails++; $display("FAIL b2b_ack i=%0d got=%b exp=%b", i, ack, (i == 10 || i == 30)); end
      update = 1'b0;
      if (i == 3)  begin duty = {24'd0, 8'd5}; update = 1'b1; end
      if (i == 4)  begin duty = {24'd0, 8'd8}; update = 1'b1; end
      if (i == 18) begin duty = {24'd0, 8'd2}; update = 1'b1; end
      @(negedge clk);
    end
    update = 1'b0;
  endtask

  // Inverted ch1, then disable mid-period and re-enable
  task automatic test_polarity_disable;
    bit ok;
    logic [CH-1:0] exp;
    load_idle(8'd9, 8'd0, 1'b0, {8'd0, 8'd0, 8'd3, 8'd0}, 4'b0010);
    start_run(ok);
    tests++;
    if (ok !== 1'b1) begin fails++; $display("FAIL pol_start got=timeout exp=pstart"); end
    for (int i = 0; i < 16; i++) begin
      exp = {2'b00, ~((i % 10) < 3), 1'b0};
      tests++;
      if (pwm !== exp) begin fails++; $display("FAIL pol_pwm i=%0d got=%b exp=%b", i, pwm, exp); end
      @(negedge clk);
    end
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (pwm !== 4'b0010) begin fails++; $display("FAIL dis_pwm k=%0d got=%b exp=0010", k, pwm); end
      tests++;
      if (pstart !== 1'b0) begin fails++; $display("FAIL dis_pstart k=%0d got=%b exp=0", k, pstart); end
    end
    start_run(ok);
    tests++;
    if (ok !== 1'b1) begin fails++; $display("FAIL reen_start got=timeout exp=pstart"); end
    for (int i = 0; i < 5; i++) begin
      exp = {2'b00, ~(i < 3), 1'b0};
      tests++;
      if (pwm !== exp) begin fails++; $display("FAIL reen_pwm i=%0d got=%b exp=%b", i, pwm, exp); end
      @(negedge clk);
    end
  endtask

  // Asynchronous reset between clock edges, then defaults
  task automatic test_async_reset;
    tests++;
    if (pwm !== 4'b0010) begin fails++; $display("FAIL pre_reset_pwm got=%b exp=0010", pwm); end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (pwm !== 4'b0000) begin fails++; $display("FAIL async_reset_pwm got=%b exp=0000", pwm); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      tests++;
      if (pwm !== 4'b0000) begin fails++; $display("FAIL post_reset_pwm i=%0d got=%b exp=0000", i, pwm); end
      tests++;
      if (ack !== 1'b0) begin fails++; $display("FAIL post_reset_ack i=%0d got=%b exp=0", i, ack); end
    end
  endtask

  initial begin
    test_reset();
    test_edge();
    test_prescale();
    test_center();
    test_update_mid_period();
    test_back_to_back();
    test_polarity_disable();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
